uart_rx_top: RTL and testbench
==============================

UART_RX_TOP -- requirements
Module: uart_rx_top

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 baud_pulse  input  1  one-clk strobe at 16x bit rate; all state advances are gated by it.
REQ-005 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 pen  input  1  parity enable.
REQ-007 eps  input  1  even parity select.
REQ-008 sticky_parity  input  1  stick parity.
REQ-009 wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-010 push  output  1  one-clk write strobe to RX FIFO.
REQ-011 dout  output  8  received word, LSB-aligned; unused upper bits are 0.
REQ-012 pe  output  1  parity error for the word on dout.
REQ-013 fe  output  1  framing error for the word on dout.
REQ-014 bi  output  1  break indication for the word on dout.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer before use; all references below mean the synchronized rx.
REQ-016 States SHALL be IDLE, START, DATA, PARITY and STOP, with a 5-bit tick counter and a 3-bit bit counter.
REQ-017 IDLE: on baud_pulse with rx=0 → START with count=7.
REQ-018 START: decrement count on each baud_pulse; at count=0 sample rx; if 1, treat it as a false start and go to IDLE; if 0, set count=15 and bitcnt=4+wls, then go to DATA.
REQ-019 DATA: at count=0, store the sample at bit index (4+wls−bitcnt), LSB first, and reload count=15; after bitcnt=0, go to PARITY if pen=1, otherwise go to STOP.
REQ-020 PARITY: at count=0, sample the parity bit; expected parity for {sticky_parity,eps} SHALL be: 00 odd (~^data), 01 even (^data), 10 constant 1, 11 constant 0, computed over the wls-selected bits only; pe=1 on mismatch.
REQ-021 STOP: at count=0, sample the stop bit; fe=1 if the sample is 0; only one stop bit is checked regardless of the transmitter's stop-bit count.
REQ-022 bi SHALL be 1 when all data bits, the parity bit (if enabled) and the stop bit were all sampled 0.
REQ-023 At the STOP sample, dout, pe, fe and bi SHALL update together and push SHALL be high for exactly one clk cycle, on the clk after that baud_pulse; the FSM then enters IDLE in the same cycle, so back-to-back frames are accepted.
REQ-024 pe, fe, bi and dout SHALL hold their values until the next push.
REQ-025 wls, pen, eps and sticky_parity SHALL be sampled continuously; changing them mid-frame yields undefined data but the FSM SHALL still return to IDLE.
REQ-026 Latency from the stop-bit mid-sample to push SHALL be 1 clk.

Reset
REQ-027 While rst=0: state=IDLE, count=0, bitcnt=0, push=0, dout=0, pe=0, fe=0, bi=0, synchronizer flops=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame without issuing push; after release, the first valid start bit SHALL be received normally.

Configuration
REQ-029 With macro UART_RX_MAJORITY_EN defined, every bit sample (START, DATA, PARITY, STOP) SHALL be the 2-of-3 majority of rx taken on the baud_pulses at count=2, 1 and 0.
REQ-030 Without UART_RX_MAJORITY_EN, every bit sample SHALL be the single rx value at count=0.

Structure
REQ-031 Package uart_pkg SHALL hold the rx state enum, TICKS_PER_BIT=16, HALF_BIT=8 and the wls encoding constants.
REQ-032 Sub-module uart_rx_sync SHALL contain the 2-flop synchronizer and the optional majority filter; the FSM and datapath SHALL live in uart_rx_top.

Verification
REQ-033 8N1 (wls=11, pen=0), frame 0xA5 at 16 pulses per bit → dout=0xA5, push for 1 clk, pe=fe=bi=0.
REQ-034 wls=10, pen=1, eps=0, sticky_parity=0, data 0x55 with parity bit 0 → dout=0x55, pe=1, fe=0.
REQ-035 rx low for 4 baud_pulses, then high → no push; FSM back in IDLE; a following 0x3C frame is received correctly.
REQ-036 8N1, 0x0F with stop bit 0 → fe=1, bi=0; rx held 0 for a full frame → dout=0x00, fe=1, bi=1.
REQ-037 With UART_RX_MAJORITY_EN, a 1-pulse glitch at mid-bit on bit 3 of 0x00 → dout=0x00; without the macro, the same glitch → dout=0x08.
REQ-038 rst asserted during DATA of 0x81 → no push, outputs 0; after release, a 0x81 frame → dout=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// oversampling ratios and word-length decode.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int TICKS_PER_BIT = 16;
    localparam int HALF_BIT      = 8;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    function automatic logic [7:0] wls_mask(input logic [1:0] wls);
        logic [7:0] mask;
        case (wls)
            WLS_5:   mask = 8'h1F;
            WLS_6:   mask = 8'h3F;
            WLS_7:   mask = 8'h7F;
            WLS_8:   mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus the bit-sample source.
// UART_RX_MAJORITY_EN: bit sample is the 2-of-3 vote over ticks at count 2, 1, 0.
module uart_rx_sync (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       baud_pulse_i,
    input  logic       rx_i,
    input  logic [4:0] count_i,
    output logic       rx_sync_o,
    output logic       bit_sample_o
);
    logic meta_q;
    logic sync_q;

    // Flops reset to 1 so a held reset looks like an idle line, not a start bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
        end
    end

    assign rx_sync_o = sync_q;

`ifdef UART_RX_MAJORITY_EN
    logic vote2_q;
    logic vote1_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vote2_q <= 1'b1;
            vote1_q <= 1'b1;
        end else if (baud_pulse_i) begin
            if (count_i == 5'd2) vote2_q <= sync_q;
            if (count_i == 5'd1) vote1_q <= sync_q;
        end
    end

    assign bit_sample_o = (vote2_q & vote1_q) | (vote2_q & sync_q) | (vote1_q & sync_q);
`else
    logic unused_vote_inputs;
    assign unused_vote_inputs = baud_pulse_i ^ (^count_i);
    assign bit_sample_o       = sync_q;
`endif

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver FSM and datapath, 16x oversampled, 5-8 data bits, optional parity.
// Optional build macro UART_RX_MAJORITY_EN enables majority-vote bit sampling.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a low sample to begin a start bit
//   START  | counting to start-bit centre, rejecting false starts
//   DATA   | sampling data bits LSB first, one per 16 ticks
//   PARITY | sampling and checking the parity bit
//   STOP   | sampling stop bit, publishing the word and flags
module uart_rx_top
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic [1:0] wls,
    output logic       push,
    output logic [7:0] dout,
    output logic       pe,
    output logic       fe,
    output logic       bi
);
    rx_state_e  state_q, state_d;
    logic [4:0] count_q, count_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] data_q, data_d;
    logic       pe_acc_q, pe_acc_d;
    logic       zero_q, zero_d;
    logic       push_q, push_d;
    logic [7:0] dout_q, dout_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       bi_q, bi_d;

    logic       rx_sync;
    logic       bit_sample;
    logic [2:0] bit_idx;
    logic [7:0] data_masked;
    logic       exp_parity;

    uart_rx_sync u_sync (
        .clk_i        (clk),
        .rst_n_i      (rst),
        .baud_pulse_i (baud_pulse),
        .rx_i         (rx),
        .count_i      (count_q),
        .rx_sync_o    (rx_sync),
        .bit_sample_o (bit_sample)
    );

    assign bit_idx     = 3'd4 + {1'b0, wls} - bitcnt_q;
    assign data_masked = data_q & wls_mask(wls);
    // Sticky parity forces the bit to ~eps; otherwise even/odd over the active bits.
    assign exp_parity  = sticky_parity ? ~eps : (eps ? ^data_masked : ~^data_masked);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        pe_acc_d = pe_acc_q;
        zero_d   = zero_q;
        push_d   = 1'b0;
        dout_d   = dout_q;
        pe_d     = pe_q;
        fe_d     = fe_q;
        bi_d     = bi_q;

        if (baud_pulse) begin
            case (state_q)
                IDLE: begin
                    if (!rx_sync) begin
                        state_d = START;
                        count_d = 5'(HALF_BIT - 1);
                    end
                end
                START: begin
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                    end else if (bit_sample) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        count_d  = 5'(TICKS_PER_BIT - 1);
                        bitcnt_d = 3'd4 + {1'b0, wls};
                        data_d   = 8'h00;
                        pe_acc_d = 1'b0;
                        zero_d   = 1'b1;
                    end
                end
                DATA: begin
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                    end else begin
                        data_d[bit_idx] = bit_sample;
                        zero_d          = zero_q & ~bit_sample;
                        count_d         = 5'(TICKS_PER_BIT - 1);
                        if (bitcnt_q == 3'd0) begin
                            state_d = pen ? PARITY : STOP;
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                    end else begin
                        pe_acc_d = (bit_sample != exp_parity);
                        zero_d   = zero_q & ~bit_sample;
                        count_d  = 5'(TICKS_PER_BIT - 1);
                        state_d  = STOP;
                    end
                end
                STOP: begin
                    if (count_q != 5'd0) begin
                        count_d = count_q - 5'd1;
                    end else begin
                        push_d  = 1'b1;
                        dout_d  = data_masked;
                        pe_d    = pe_acc_q;
                        fe_d    = ~bit_sample;
                        bi_d    = zero_q & ~bit_sample;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            bitcnt_q <= 3'd0;
            data_q   <= 8'h00;
            pe_acc_q <= 1'b0;
            zero_q   <= 1'b0;
            push_q   <= 1'b0;
            dout_q   <= 8'h00;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            bi_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            pe_acc_q <= pe_acc_d;
            zero_q   <= zero_d;
            push_q   <= push_d;
            dout_q   <= dout_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
            bi_q     <= bi_d;
        end
    end

    assign push = push_q;
    assign dout = dout_q;
    assign pe   = pe_q;
    assign fe   = fe_q;
    assign bi   = bi_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Bench for uart_rx_top: directed frames from the verification list plus
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_top;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_pulse = 1'b0;
    logic       rx = 1'b1;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_parity = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       push;
    logic [7:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;

    int checks = 0;
    int failures = 0;

    logic [10:0] mon_q[$];

    uart_rx_top u_dut (
        .clk           (clk),
        .rst           (rst),
        .baud_pulse    (baud_pulse),
        .rx            (rx),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .wls           (wls),
        .push          (push),
        .dout          (dout),
        .pe            (pe),
        .fe            (fe),
        .bi            (bi)
    );

    always #5 clk = ~clk;

    // Every clk with push high is logged, so a stretched push shows up as extra entries.
    always @(negedge clk) begin
        if (rst && push) mon_q.push_back({bi, fe, pe, dout});
    end

    initial begin
        #3ms;
        $display("FAIL timeout: bench exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One baud tick: 4 clks, rx held, strobe on the last clk.
    task automatic tick(input logic v);
        rx = v;
        repeat (3) @(negedge clk);
        baud_pulse = 1'b1;
        @(negedge clk);
        baud_pulse = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        repeat (16) tick(v);
    endtask

    task automatic idle_gap();
        repeat (20) tick(1'b1);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic [1:0] w, input logic p,
                               input logic pb, input logic sb);
        drive_bit(1'b0);
        for (int i = 0; i < 5 + int'(w); i++) drive_bit(d[i]);
        if (p) drive_bit(pb);
        drive_bit(sb);
        idle_gap();
    endtask

    // Reference: {bi, fe, pe, dout} from the frame contents as transmitted.
    function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] w,
                                          input logic p, input logic e, input logic s,
                                          input logic pb, input logic sb);
        logic [7:0] all_ones = 8'hFF;
        logic [7:0] m;
        int         ones;
        logic       exp_pb;
        logic       x_pe, x_fe, x_bi;
        m    = d & ~(all_ones << (5 + int'(w)));
        ones = $countones(m);
        if (s)      exp_pb = ~e;
        else if (e) exp_pb = (ones % 2 == 1);
        else        exp_pb = (ones % 2 == 0);
        x_pe = p && (pb != exp_pb);
        x_fe = !sb;
        x_bi = (m == 8'h00) && (!p || !pb) && !sb;
        return {x_bi, x_fe, x_pe, m};
    endfunction

    task automatic expect_frame(input string tag, input logic [10:0] exp);
        logic [10:0] got;
        check({tag, "_push_count"}, mon_q.size(), 1);
        got = (mon_q.size() > 0) ? mon_q[0] : 11'h7FF;
        mon_q.delete();
        check({tag, "_dout"}, got[7:0], exp[7:0]);
        check({tag, "_pe"}, got[8], exp[8]);
        check({tag, "_fe"}, got[9], exp[9]);
        check({tag, "_bi"}, got[10], exp[10]);
        check({tag, "_dout_held"}, dout, exp[7:0]);
    endtask

    task automatic send_check(input string tag, input logic [7:0] d, input logic [1:0] w,
                              input logic p, input logic e, input logic s,
                              input logic pb, input logic sb);
        wls = w;
        pen = p;
        eps = e;
        sticky_parity = s;
        drive_frame(d, w, p, pb, sb);
        expect_frame(tag, model(d, w, p, e, s, pb, sb));
    endtask

    initial begin
        logic [10:0] exp_glitch;

        repeat (4) @(negedge clk);
        check("reset_push", push, 1'b0);
        check("reset_dout", dout, 8'h00);
        check("reset_flags", {pe, fe, bi}, 3'b000);
        rst = 1'b1;
        idle_gap();
        check("idle_no_push", mon_q.size(), 0);

        send_check("8n1_a5", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_check("7o_55_bad_par", 8'h55, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        wls = 2'b11;
        pen = 1'b0;
        repeat (4) tick(1'b0);
        idle_gap();
        check("false_start_no_push", mon_q.size(), 0);
        send_check("after_false_3c", 8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        send_check("8n1_0f_stop0", 8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_check("break", 8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single high tick at the centre of data bit 3 of 0x00.
        wls = 2'b11;
        pen = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                repeat (8) tick(1'b0);
                tick(1'b1);
                repeat (7) tick(1'b0);
            end else begin
                drive_bit(1'b0);
            end
        end
        drive_bit(1'b1);
        idle_gap();
`ifdef UART_RX_MAJORITY_EN
        exp_glitch = {1'b0, 1'b0, 1'b0, 8'h00};
`else
        exp_glitch = {1'b0, 1'b0, 1'b0, 8'h08};
`endif
        expect_frame("glitch_bit3", exp_glitch);

        send_check("pre_reset_c3", 8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        repeat (5) tick(1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_dout", dout, 8'h00);
        check("midreset_flags", {push, pe, fe, bi}, 4'b0000);
        rx = 1'b1;
        rst = 1'b1;
        idle_gap();
        check("midreset_no_push", mon_q.size(), 0);
        send_check("after_reset_81", 8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        send_check("5e_sticky1", 8'h13, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        send_check("6s_sticky0_bad", 8'h2A, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_check("8e_good", 8'hB7, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic [1:0] w;
            logic       p, e, s, pb, sb;
            d  = 8'($urandom);
            w  = 2'($urandom_range(3));
            p  = 1'($urandom_range(1));
            e  = 1'($urandom_range(1));
            s  = 1'($urandom_range(1));
            pb = 1'($urandom_range(1));
            sb = ($urandom_range(7) != 0);
            send_check($sformatf("rand%0d", n), d, w, p, e, s, pb, sb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
